// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory: FSM encoding, default
// program pattern and the fetch range check.
package instr_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_e;

  // Last byte of each slot carries the slot index; the other bytes are zero.
  function automatic logic [7:0] default_byte(input int unsigned addr,
                                              input int unsigned instr_bytes);
    if ((addr % instr_bytes) == (instr_bytes - 1)) begin
      return 8'(addr / instr_bytes);
    end
    return 8'h00;
  endfunction

  // Widened by one bit so that addresses near the top of the bus cannot wrap.
  function automatic logic addr_in_range(input logic [32:0] addr,
                                         input int unsigned instr_bytes,
                                         input int unsigned depth_bytes);
    logic [33:0] last;
    last = {1'b0, addr} + 34'(instr_bytes) - 34'd1;
    return last < 34'(depth_bytes);
  endfunction

endpackage

// File: rtl/instr_byte_ram.sv
// Plain byte array: one lane-enabled write port and Lanes combinational read taps.
// Taps and write lanes that fall past the end of the array read zero / are ignored.
module instr_byte_ram #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LANES       = 2
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [LANES-1:0]     wr_be_i,
  input  logic [8*LANES-1:0]   wr_data_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [8*LANES-1:0]   rd_data_o
);

  localparam int unsigned IdxW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH_BYTES);

  logic [7:0]      mem_q [DEPTH_BYTES];
  logic [ADDR_W:0] w_idx [LANES];
  logic [ADDR_W:0] r_idx [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_idx[g] = {1'b0, wr_addr_i} + (ADDR_W + 1)'(g);
    assign r_idx[g] = {1'b0, rd_addr_i} + (ADDR_W + 1)'(g);
    assign rd_data_o[8*g +: 8] = (r_idx[g] < DepthExt) ? mem_q[r_idx[g][IdxW-1:0]] : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en_i && wr_be_i[i] && (w_idx[i] < DepthExt)) begin
        mem_q[w_idx[i][IdxW-1:0]] <= wr_data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory with self-fill after reset, byte load port and a registered
// valid/ready fetch port (one-cycle latency, full throughput).
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned INSTR_BYTES = 2,
  parameter int unsigned ALIGN_CHECK = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_done,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [8*INSTR_BYTES-1:0] rsp_instr,
  output logic                     rsp_err,
  input  logic                     load_en,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [7:0]               load_data
);

  localparam int unsigned IW    = 8 * INSTR_BYTES;
  localparam int unsigned Slots = DEPTH_BYTES / INSTR_BYTES;
  localparam int unsigned CntW  = (Slots > 1) ? $clog2(Slots) : 1;
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH_BYTES);

  state_e          state_q, state_d;
  logic [CntW-1:0] fill_cnt_q, fill_cnt_d;
  logic            init_done_q, init_done_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_instr_q, rsp_instr_d;
  logic            rsp_err_q, rsp_err_d;

  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [INSTR_BYTES-1:0] wr_be;
  logic [IW-1:0]          wr_data;
  logic [ADDR_W-1:0]      fill_base;
  logic [IW-1:0]          fill_data;
  logic [IW-1:0]          rd_bytes;
  logic [IW-1:0]          rd_instr;
  logic                   req_fire;
  logic                   req_ok;
  logic                   misaligned;
  logic                   load_in_range;

  assign fill_base = ADDR_W'(fill_cnt_q) * ADDR_W'(INSTR_BYTES);

  // Lane g of the RAM is byte addr+g; the first byte is the instruction MSB.
  for (genvar g = 0; g < INSTR_BYTES; g++) begin : g_bytes
    assign fill_data[8*g +: 8] = default_byte(32'(fill_base) + 32'(g), INSTR_BYTES);
    assign rd_instr[IW-1-8*g -: 8] = rd_bytes[8*g +: 8];
  end

  assign req_ready     = init_done_q && (!rsp_valid_q || rsp_ready);
  assign req_fire      = req_valid && req_ready;
  assign misaligned    = (32'(req_addr) % INSTR_BYTES) != 0;
  assign req_ok        = addr_in_range(33'(req_addr), INSTR_BYTES, DEPTH_BYTES) &&
                         !((ALIGN_CHECK != 0) && misaligned);
  assign load_in_range = {1'b0, load_addr} < DepthExt;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_be       = '0;
    wr_data     = '0;

    unique case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = fill_base;
        wr_be   = '1;
        wr_data = fill_data;
        if (fill_cnt_q == CntW'(Slots - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (load_en && load_in_range) begin
          wr_en        = 1'b1;
          wr_addr      = load_addr;
          wr_be        = INSTR_BYTES'(1);
          wr_data[7:0] = load_data;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Read taps see the array before this edge's write: read-before-write.
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !req_ok;
      rsp_instr_d = req_ok ? rd_instr : '0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      fill_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  instr_byte_ram #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH_BYTES),
    .LANES       (INSTR_BYTES)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_be_i   (wr_be),
    .wr_data_i (wr_data),
    .rd_addr_i (req_addr),
    .rd_data_o (rd_bytes)
  );

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench for instr_mem_pipe; a second instance with ALIGN_CHECK=1
// shares all inputs so both alignment modes are checked on the same traffic.
module tb_instr_mem_pipe;

  typedef struct {
    logic [15:0] instr;
    logic        err;
    logic [15:0] instr_al;
    logic        err_al;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic        rsp_ready = 1'b1;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [7:0]  load_data = '0;

  logic        init_done, req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_instr;
  logic        init_done_al, req_ready_al, rsp_valid_al, rsp_err_al;
  logic [15:0] rsp_instr_al;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  bit   running = 1'b0;
  logic [7:0] mm [256];
  exp_t sb [$];

  always #5 clk = ~clk;

  instr_mem_pipe #(.ADDR_W(16), .DEPTH_BYTES(256), .INSTR_BYTES(2), .ALIGN_CHECK(0)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instr_mem_pipe #(.ADDR_W(16), .DEPTH_BYTES(256), .INSTR_BYTES(2), .ALIGN_CHECK(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_al), .req_valid(req_valid),
    .req_ready(req_ready_al), .req_addr(req_addr), .rsp_valid(rsp_valid_al),
    .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_al), .rsp_err(rsp_err_al),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic model_reset();
    for (int a = 0; a < 256; a++) mm[a] = (a % 2 == 1) ? 8'(a / 2) : 8'h00;
  endtask

  function automatic exp_t model_exp(input int a);
    exp_t e;
    if (a + 1 < 256) begin
      e.instr = {mm[a], mm[a+1]};
      e.err   = 1'b0;
    end else begin
      e.instr = 16'h0000;
      e.err   = 1'b1;
    end
    e.instr_al = (a % 2 != 0) ? 16'h0000 : e.instr;
    e.err_al   = (a % 2 != 0) ? 1'b1 : e.err;
    return e;
  endfunction

  // One clock: score the handshakes seen before the edge, then advance.
  task automatic cycle();
    exp_t e;
    #2;
    if (rsp_valid && !rsp_ready && sb.size() > 0) begin
      checks++;
      if (rsp_instr !== sb[0].instr) begin
        failures++;
        $display("FAIL stall_hold instr=%h required=%h", rsp_instr, sb[0].instr);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready req_ready=%b required=0", req_ready);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected instr=%h required=no response", rsp_instr);
      end else begin
        e = sb.pop_front();
        pops++;
        checks++;
        if (rsp_instr !== e.instr) begin
          failures++;
          $display("FAIL rsp_instr got=%h required=%h", rsp_instr, e.instr);
        end
        checks++;
        if (rsp_err !== e.err) begin
          failures++;
          $display("FAIL rsp_err got=%b required=%b", rsp_err, e.err);
        end
        checks++;
        if (rsp_valid_al !== 1'b1 || rsp_instr_al !== e.instr_al) begin
          failures++;
          $display("FAIL al_instr valid=%b got=%h required=%h", rsp_valid_al, rsp_instr_al,
                   e.instr_al);
        end
        checks++;
        if (rsp_err_al !== e.err_al) begin
          failures++;
          $display("FAIL al_err got=%b required=%b", rsp_err_al, e.err_al);
        end
      end
    end
    if (req_valid && req_ready) sb.push_back(model_exp(int'(req_addr)));
    if (running && load_en && load_addr < 16'd256) mm[load_addr[7:0]] = load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 300) begin
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_ready_early cycle=%0d req_ready=%b required=0", name, n, req_ready);
      end
      cycle();
      n++;
    end
    checks++;
    if (n < 127 || n > 129) begin
      failures++;
      $display("FAIL %s_fill_time cycles=%0d required=128", name, n);
    end
    running = 1'b1;
  endtask

  task automatic fetch_one(input logic [15:0] a);
    req_addr  = a;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency addr=%h rsp_valid=%b required=1", a, rsp_valid);
    end
    cycle();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_drop addr=%h rsp_valid=%b required=0", a, rsp_valid);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({init_done, req_ready, rsp_valid, rsp_err, rsp_instr} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state init=%b rdy=%b vld=%b err=%b instr=%h required=all zero",
               init_done, req_ready, rsp_valid, rsp_err, rsp_instr);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    rsp_ready = 1'b1;
    wait_init("init");
    cycle();
    req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_fetch();
    fetch_one(16'h0006);
    fetch_one(16'h0001);
    fetch_one(16'h0003);
    fetch_one(16'h00FF);
    fetch_one(16'h00FE);
    fetch_one(16'hFFFF);
    fetch_one(16'h0010);
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    cycle();
    req_addr = 16'h0002;
    cycle();
    rsp_ready = 1'b0;
    req_addr  = 16'h0004;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    checks++;
    if (pops - p0 != 3) begin
      failures++;
      $display("FAIL b2b_count responses=%0d required=3", pops - p0);
    end
  endtask

  task automatic test_load();
    load_en   = 1'b1;
    load_addr = 16'h0011;
    load_data = 8'h55;
    req_addr  = 16'h0010;
    req_valid = 1'b1;
    cycle();
    load_en   = 1'b0;
    req_valid = 1'b0;
    cycle();
    fetch_one(16'h0010);
    load_en   = 1'b1;
    load_addr = 16'h0010;
    load_data = 8'hAB;
    cycle();
    load_addr = 16'h0011;
    load_data = 8'hCD;
    cycle();
    load_addr = 16'h0100;
    load_data = 8'hEE;
    cycle();
    load_en = 1'b0;
    fetch_one(16'h0010);
    fetch_one(16'h0000);
    fetch_one(16'h00FE);
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_addr  = 16'h0010;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_valid_al !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset rsp_valid=%b init_done=%b required=0 0", rsp_valid, init_done);
    end
    sb.delete();
    model_reset();
    running = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    wait_init("reinit");
    fetch_one(16'h0010);
    fetch_one(16'h0011);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_load();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
